// File: rtl/spi_flash_seq.sv
`default_nettype none
// ============================================================================
// spi_flash_seq : turns one "read N bytes at A" request into a flash READ (0x03)
// Rev 1.0
// ============================================================================
module spi_flash_seq #(
  parameter int STROBE_CYC = 18,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  input  logic [23:0]      req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             req_ready_o,
  output logic             rd_valid_o,
  output logic [7:0]       rd_data_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             spi_cs_n_o,
  output logic             spi_enviar_o,
  output logic             spi_recibir_o,
  output logic [7:0]       spi_din_o,
  input  logic [7:0]       spi_dout_i
);

  localparam int c_TMAX_A = (STROBE_CYC > CS_SETUP) ? STROBE_CYC : CS_SETUP;
  localparam int c_TMAX   = (c_TMAX_A > CS_HOLD) ? c_TMAX_A : CS_HOLD;
  localparam int c_TW     = $clog2(c_TMAX + 1);

  localparam logic [c_TW-1:0]  c_GAP        = c_TW'(STROBE_CYC);
  localparam logic [c_TW-1:0]  c_LAST_HI    = c_TW'(STROBE_CYC - 1);
  localparam logic [c_TW-1:0]  c_SETUP_LAST = c_TW'(CS_SETUP - 1);
  localparam logic [c_TW-1:0]  c_HOLD_LAST  = c_TW'(CS_HOLD - 1);
  localparam logic [c_TW-1:0]  c_TICK_ONE   = c_TW'(1);
  localparam logic [LEN_W-1:0] c_LEN_ONE    = LEN_W'(1);
  localparam logic [7:0]       c_CMD_READ   = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SEND  = 3'd2,
    ST_PRIME = 3'd3,
    ST_READ  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [c_TW-1:0]  tick_q, tick_d;
  logic [1:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [23:0]      addr_q, addr_d;

  logic       cs_n_q, cs_n_d;
  logic       enviar_q, enviar_d;
  logic       recibir_q, recibir_d;
  logic [7:0] din_q, din_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  // Slot states count tick 0..STROBE_CYC-1 with the strobe high, tick STROBE_CYC is the gap.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    len_d   = len_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          len_d   = req_len_i;
          tick_d  = '0;
          idx_d   = '0;
          state_d = (req_len_i == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick_q == c_SETUP_LAST) begin
          tick_d  = '0;
          state_d = ST_SEND;
        end else begin
          tick_d = tick_q + c_TICK_ONE;
        end
      end
      ST_SEND: begin
        if (tick_q == c_GAP) begin
          tick_d = '0;
          if (idx_q == 2'd3) begin
            state_d = ST_PRIME;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          tick_d = tick_q + c_TICK_ONE;
        end
      end
      ST_PRIME: begin
        if (tick_q == c_GAP) begin
          tick_d  = '0;
          state_d = ST_READ;
        end else begin
          tick_d = tick_q + c_TICK_ONE;
        end
      end
      ST_READ: begin
        if (tick_q == c_GAP) begin
          tick_d = '0;
          len_d  = len_q - c_LEN_ONE;
          if (len_q == c_LEN_ONE) begin
            state_d = ST_HOLD;
          end
        end else begin
          tick_d = tick_q + c_TICK_ONE;
        end
      end
      ST_HOLD: begin
        if (tick_q == c_HOLD_LAST) begin
          tick_d  = '0;
          state_d = ST_DONE;
        end else begin
          tick_d = tick_q + c_TICK_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    cs_n_d    = (state_d == ST_IDLE) || (state_d == ST_DONE);
    enviar_d  = (state_d == ST_SEND) && (tick_d != c_GAP);
    recibir_d = ((state_d == ST_PRIME) || (state_d == ST_READ)) && (tick_d != c_GAP);
    din_d     = 8'h00;
    if (state_d == ST_SEND) begin
      case (idx_d)
        2'd0:    din_d = c_CMD_READ;
        2'd1:    din_d = addr_d[23:16];
        2'd2:    din_d = addr_d[15:8];
        default: din_d = addr_d[7:0];
      endcase
    end
    rd_valid_d = (state_q == ST_READ) && (tick_q == c_LAST_HI);
    rd_data_d  = rd_valid_d ? spi_dout_i : rd_data_q;
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
    ready_d    = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      cs_n_q     <= 1'b1;
      enviar_q   <= 1'b0;
      recibir_q  <= 1'b0;
      din_q      <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      cs_n_q     <= cs_n_d;
      enviar_q   <= enviar_d;
      recibir_q  <= recibir_d;
      din_q      <= din_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_data_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign spi_cs_n_o    = cs_n_q;
  assign spi_enviar_o  = enviar_q;
  assign spi_recibir_o = recibir_q;
  assign spi_din_o     = din_q;

endmodule
`default_nettype wire
